monte_bus_initiator: RTL
========================

// Module: monte_bus_initiator
// PURPOSE
//  Bus initiator (master) for the uart2bus internal bus; drives the Monte-Carlo stat responder from on-chip logic, not UART.
//  Per job: writes 16 board cells (addr 0..15), writes seed (addr 16), waits RUN_CYCLES, reads 40 stat bytes (addr 17..56).
//  Presents the assembled 320-bit result and pulses done. Sits beside uart2bus_top as a second bus source.
// PARAMETERS
//  ADDR_W      16         bus address width
//  CELL_W      5          bits per board cell in board input (zero-extended to 8 on bus)
//  RUN_CYCLES  1000000    clk cycles between seed write and first stat read (>=1)
//  STAT_BASE   17         address of direction-0 stat byte 0
//  STAT_STRIDE 10         bytes per direction block
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous reset, active-high
//  start        in   1        job request; accepted only in IDLE
//  board        in   16*CELL_W cell i at [CELL_W*i +: CELL_W]; sampled at accept
//  seed         in   8        RNG seed; sampled at accept
//  busy         out  1        high from accept until done cycle inclusive
//  done         out  1        one-cycle pulse, job finished
//  err          out  1        valid with done: 1 = seed was 0, no stats read
//  stats        out  320      dir d at [80*d +: 80] = {trial[31:0], total_move[31:0], max_move[15:0]}
//  int_address  out  ADDR_W   bus address
//  int_wr_data  out  8        bus write data
//  int_write    out  1        write strobe, one cycle per beat
//  int_read     out  1        read strobe, one cycle per beat
//  int_rd_data  in   8        read data, valid the cycle after int_read
//  int_req      out  1        bus request
//  int_gnt      in   1        bus grant
// BEHAVIOUR
//  Reset: all outputs 0, stats 0, FSM IDLE, counters 0. Reset mid-job aborts at once; no further beats.
//  Handshake: int_req high in WR_GRID/WR_SEED/RD states. A beat issues (strobe high one cycle) only in a cycle
//   with int_req & int_gnt; gnt low -> strobes low, address/data held, beat retried. Never write & read same cycle.
//  FSM: IDLE -(start)-> WR_GRID (beats i=0..15, addr=i, data={0,cell i}) -> WR_SEED (addr 16, data=seed)
//   -> seed==0 ? FIN(err=1) : WAIT -> RD -> DRAIN -> FIN -> IDLE.
//  WAIT: counts RUN_CYCLES clocks, int_req low, bus idle.
//  RD: 40 read beats, addr = STAT_BASE + k, k=0..39, back-to-back when granted. Byte k captured the cycle after
//   its strobe into stats byte (k/10)*80 + (k%10)*8 (little-endian per field). DRAIN: capture of final byte.
//  FIN: done=1, busy=1 for that cycle; next cycle IDLE, busy=0. stats hold until next successful capture.
//  start while busy ignored; start in FIN cycle ignored; start in IDLE with done just low accepted.
//  Latency, gnt tied 1, seed!=0: accept at cycle 0 -> writes cycles 1..17 -> WAIT RUN_CYCLES -> 40 reads -> DRAIN
//   -> done at cycle 17+RUN_CYCLES+42. Seed 0: done at cycle 18, err=1, stats unchanged.
//  Counters: beat index 6 bits, wait counter 32 bits, saturate-free; no wrap inside a job.
// CONFIGURATION
//  MBI_ABORT_EN defined: adds input abort (1 bit). abort high while busy -> finish current issued beat (incl. its
//   capture), then one write addr 16 data 0 (responder reset), then FIN with err=1; stats partially updated bytes kept.
//   abort in IDLE or FIN ignored.
//  Undefined: no abort port; job always runs to completion or reset.
// STRUCTURE
//  Shared package mbi_pkg: state enum (IDLE, WR_GRID, WR_SEED, WAIT, RD, DRAIN, FIN), ADDR_GRID0=0, ADDR_SEED=16,
//   STAT_BASE/STAT_STRIDE, N_DIR=4, BYTES_PER_DIR=10, field offsets (max_move 0, total_move 2, trial 6).
//  One sub-module: mbi_beat_engine (req/gnt beat issue + one-cycle read capture pipeline); FSM + stats regs in top.
// TESTING
//  gnt=1, board cell i = i, seed=0x5A, RUN_CYCLES=4 -> writes addr0..15 data 0x00..0x0F, addr16 0x5A; reads 17..56; done at cycle 63.
//  Model responder returns addr as data -> stats byte k = 17+k; dir1 max_move = 0x1C1B; err=0.
//  gnt toggling 1,0,1,0 during RD -> strobes only on gnt cycles, no byte lost/duplicated, same stats as gnt=1.
//  seed=0 -> 17 writes, no reads, done at cycle 18 with err=1, stats unchanged from previous job.
//  rst pulsed during WAIT -> outputs 0 next cycle, no read beats; new start runs full job correctly.
//  MBI_ABORT_EN: abort at 5th read beat -> 5 bytes captured, write addr16 data0, done with err=1.

Source files
------------

// File: rtl/mbi_pkg.sv
// rtl/mbi_pkg.sv - shared states, addresses and stat layout for monte_bus_initiator
package mbi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_GRID,
        WR_SEED,
        WAIT,
        RD,
        DRAIN,
        FIN
    } state_t;

    localparam int BEAT_W          = 6;
    localparam int ADDR_GRID0      = 0;
    localparam int ADDR_SEED       = 16;
    localparam int N_CELLS         = 16;
    localparam int DEF_STAT_BASE   = 17;
    localparam int DEF_STAT_STRIDE = 10;
    localparam int N_DIR           = 4;
    localparam int BYTES_PER_DIR   = 10;
    localparam int N_STAT          = N_DIR * BYTES_PER_DIR;
    localparam int DIR_BITS        = BYTES_PER_DIR * 8;
    localparam int OFS_MAX_MOVE    = 0;
    localparam int OFS_TOTAL_MOVE  = 2;
    localparam int OFS_TRIAL       = 6;

    // Bit position of stat byte k inside the packed result vector.
    function automatic int stat_lsb(input int k, input int stride);
        return (k / stride) * DIR_BITS + (k % stride) * 8;
    endfunction

endpackage

// File: rtl/mbi_beat_engine.sv
// rtl/mbi_beat_engine.sv - req/gnt beat issue and one-cycle read capture pipeline
module mbi_beat_engine
    import mbi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              is_write,
    input  logic [BEAT_W-1:0] beat_idx,
    input  logic              int_gnt,
    output logic              int_req,
    output logic              int_write,
    output logic              int_read,
    output logic              fire,
    output logic              cap_valid,
    output logic [BEAT_W-1:0] cap_idx
);

    // A beat only goes out in a cycle where the arbiter grants; otherwise it is retried.
    assign int_req   = req;
    assign fire      = req & int_gnt;
    assign int_write = fire & is_write;
    assign int_read  = fire & ~is_write;

    // Read data arrives the cycle after the strobe, so remember which byte it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_idx   <= '0;
        end else begin
            cap_valid <= int_read;
            if (int_read) begin
                cap_idx <= beat_idx;
            end
        end
    end

endmodule

// File: rtl/monte_bus_initiator.sv
// rtl/monte_bus_initiator.sv - job FSM driving the stat responder; optional MBI_ABORT_EN adds abort input
module monte_bus_initiator
    import mbi_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int CELL_W      = 5,
    parameter int RUN_CYCLES  = 1000000,
    parameter int STAT_BASE   = DEF_STAT_BASE,
    parameter int STAT_STRIDE = DEF_STAT_STRIDE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef MBI_ABORT_EN
    input  logic                  abort,
`endif
    input  logic [16*CELL_W-1:0]  board,
    input  logic [7:0]            seed,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [N_DIR*DIR_BITS-1:0] stats,
    output logic [ADDR_W-1:0]     int_address,
    output logic [7:0]            int_wr_data,
    output logic                  int_write,
    output logic                  int_read,
    input  logic [7:0]            int_rd_data,
    output logic                  int_req,
    input  logic                  int_gnt
);

    localparam logic [31:0]       RUN_LAST   = 32'(RUN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_STAT0 = ADDR_W'(STAT_BASE);

    state_t              state;
    logic [BEAT_W-1:0]   idx;
    logic [BEAT_W-1:0]   nidx;
    logic [31:0]         wait_cnt;
    logic [16*CELL_W-1:0] board_r;
    logic [7:0]          seed_r;
    logic                req_r;
    logic                is_wr;
    logic                aborting;
    logic                abort_in;
    logic                abort_hit;
    logic                fire;
    logic                cap_valid;
    logic [BEAT_W-1:0]   cap_idx;
    logic [ADDR_W-1:0]   addr_r;
    logic [7:0]          wdata_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic [CELL_W-1:0]   cells [N_CELLS];
    logic [7:0]          stat_bytes [N_STAT];

`ifdef MBI_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    for (genvar i = 0; i < N_CELLS; i++) begin : g_cells
        assign cells[i] = board_r[CELL_W*i +: CELL_W];
    end

    assign nidx      = idx + BEAT_W'(1);
    assign abort_hit = abort_in && !aborting && (state != IDLE) && (state != FIN);

    mbi_beat_engine u_beat (
        .clk       (clk),
        .rst       (rst),
        .req       (req_r),
        .is_write  (is_wr),
        .beat_idx  (idx),
        .int_gnt   (int_gnt),
        .int_req   (int_req),
        .int_write (int_write),
        .int_read  (int_read),
        .fire      (fire),
        .cap_valid (cap_valid),
        .cap_idx   (cap_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            wait_cnt <= '0;
            board_r  <= '0;
            seed_r   <= '0;
            req_r    <= 1'b0;
            is_wr    <= 1'b0;
            aborting <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else if (abort_hit) begin
            // Whatever beat fired this cycle has completed; a zero seed write resets the responder.
            state    <= WR_SEED;
            req_r    <= 1'b1;
            is_wr    <= 1'b1;
            aborting <= 1'b1;
            addr_r   <= ADDR_W'(ADDR_SEED);
            wdata_r  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= WR_GRID;
                        board_r <= board;
                        seed_r  <= seed;
                        idx     <= '0;
                        req_r   <= 1'b1;
                        is_wr   <= 1'b1;
                        addr_r  <= ADDR_W'(ADDR_GRID0);
                        wdata_r <= 8'(board[CELL_W-1:0]);
                        busy_r  <= 1'b1;
                    end
                end
                WR_GRID: begin
                    if (fire) begin
                        if (idx == BEAT_W'(N_CELLS - 1)) begin
                            state   <= WR_SEED;
                            addr_r  <= ADDR_W'(ADDR_SEED);
                            wdata_r <= seed_r;
                        end else begin
                            idx     <= nidx;
                            addr_r  <= ADDR_W'(ADDR_GRID0) + ADDR_W'(nidx);
                            wdata_r <= 8'(cells[nidx[3:0]]);
                        end
                    end
                end
                WR_SEED: begin
                    if (fire) begin
                        req_r <= 1'b0;
                        if (aborting || seed_r == 8'h00) begin
                            state  <= FIN;
                            done_r <= 1'b1;
                            err_r  <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == RUN_LAST) begin
                        state  <= RD;
                        req_r  <= 1'b1;
                        is_wr  <= 1'b0;
                        idx    <= '0;
                        addr_r <= ADDR_STAT0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                RD: begin
                    if (fire) begin
                        if (idx == BEAT_W'(N_STAT - 1)) begin
                            state <= DRAIN;
                            req_r <= 1'b0;
                        end else begin
                            idx    <= nidx;
                            addr_r <= addr_r + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    state  <= FIN;
                    done_r <= 1'b1;
                end
                FIN: begin
                    state    <= IDLE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    err_r    <= 1'b0;
                    aborting <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_STAT; k++) begin
                stat_bytes[k] <= '0;
            end
        end else if (cap_valid) begin
            stat_bytes[cap_idx] <= int_rd_data;
        end
    end

    for (genvar k = 0; k < N_STAT; k++) begin : g_stats
        assign stats[stat_lsb(k, STAT_STRIDE) +: 8] = stat_bytes[k];
    end

    assign int_address = addr_r;
    assign int_wr_data = wdata_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule
